// File: rtl/cia_pkg.sv
// Shared CIA register types and constants used by the serial-port sequencer.
package cia;

    typedef logic [7:0] reg8_t;
    typedef logic [3:0] reg4_t;

    localparam reg4_t SDR_ADDR = 4'hC;

    typedef enum logic {IDLE, WRITE} sp_seq_state_t;

endpackage

// File: rtl/cia_sp_fifo.sv
// Byte FIFO for the serial-port sequencer; power-of-two depth, synchronous active-high reset.
module cia_sp_fifo
    import cia::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  reg8_t                    push_data,
    input  logic                     pop,
    output reg8_t                    head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    reg8_t       mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        level   = wr_q - rd_q;
        full    = (level == (AW + 1)'(DEPTH));
        empty   = (wr_q == rd_q);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = wr_q + (AW + 1)'(do_push);
        rd_d    = rd_q + (AW + 1)'(do_pop);
        head    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cia_sp_sequencer.sv
// Paces host bytes into the CIA serial data register, keeping at most two in flight.
// Optional receive capture path is enabled by defining CIA_SP_SEQ_RX_EN.
module cia_sp_sequencer
    import cia::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     phi2_up,
    input  logic                     phi2_dn,
    input  logic                     txmode,
    input  logic                     sp_int,
    input  logic [7:0]               sp_regs,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     sp_we,
    output logic [3:0]               sp_addr,
    output logic [7:0]               sp_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     rx_valid,
    output logic [7:0]               rx_data,
    output logic                     rx_ovr,
    input  logic                     rx_ack
);

    sp_seq_state_t state_q, state_d;
    logic          sp_we_q, sp_we_d;
    reg8_t         sp_data_q, sp_data_d;
    logic [1:0]    outstanding_q, outstanding_d;
    logic [1:0]    outstanding_clr;
    logic          txmode_q, txmode_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    reg8_t         fifo_head;

    logic          issue;
    logic          commit;
    logic          retire;
    logic          tx_change;

    cia_sp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (in_valid & in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        // A pending sp_int holds off issue so the outstanding count settles first.
        issue     = (state_q == IDLE) & phi2_up & txmode & ~fifo_empty
                    & (outstanding_q != 2'd2) & ~sp_int;
        commit    = (state_q == WRITE) & phi2_dn & txmode;
        tx_change = phi2_dn & (txmode != txmode_q);
        fifo_pop  = commit;

        state_d   = state_q;
        sp_we_d   = sp_we_q;
        sp_data_d = sp_data_q;
        txmode_d  = phi2_dn ? txmode : txmode_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = WRITE;
                    sp_we_d   = 1'b1;
                    sp_data_d = fifo_head;
                end
            end
            WRITE: begin
                if (phi2_dn) begin
                    state_d = IDLE;
                    sp_we_d = 1'b0;
                end
            end
        endcase

        outstanding_clr = tx_change ? 2'd0 : outstanding_q;
        retire          = phi2_up & sp_int & (outstanding_clr != 2'd0);
        outstanding_d   = outstanding_clr + 2'(commit) - 2'(retire);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= IDLE;
            sp_we_q       <= 1'b0;
            sp_data_q     <= '0;
            outstanding_q <= '0;
            txmode_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_we_q       <= sp_we_d;
            sp_data_q     <= sp_data_d;
            outstanding_q <= outstanding_d;
            txmode_q      <= txmode_d;
        end
    end

    assign sp_we    = sp_we_q;
    assign sp_data  = sp_data_q;
    assign sp_addr  = SDR_ADDR;
    assign in_ready = ~fifo_full;
    assign busy     = (outstanding_q != 2'd0) | ~fifo_empty;

`ifdef CIA_SP_SEQ_RX_EN
    logic  rx_arm_q, rx_arm_d;
    logic  rx_valid_q, rx_valid_d;
    logic  rx_ovr_q, rx_ovr_d;
    reg8_t rx_data_q, rx_data_d;
    logic  rx_capture;

    // Arm on the byte-complete edge; SDR holds the new byte by the following phi2_up.
    always_comb begin
        rx_capture = phi2_up & rx_arm_q;
        rx_arm_d   = phi2_up ? (sp_int & ~txmode) : rx_arm_q;
        rx_valid_d = rx_valid_q & ~rx_ack;
        rx_data_d  = rx_data_q;
        rx_ovr_d   = rx_ovr_q;
        if (rx_capture) begin
            rx_valid_d = 1'b1;
            rx_data_d  = sp_regs;
            if (rx_valid_q & ~rx_ack) begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rx_arm_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_arm_q   <= rx_arm_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_ovr   = rx_ovr_q;
`else
    logic unused_rx;
    assign unused_rx = rx_ack ^ (^sp_regs);
    assign rx_valid  = 1'b0;
    assign rx_data   = '0;
    assign rx_ovr    = 1'b0;
`endif

endmodule

// File: tb/tb_cia_sp_sequencer.sv
// Directed bench for cia_sp_sequencer with a small behavioural cia_serial shifter model.
module tb_cia_sp_sequencer;

    logic       clk = 1'b0;
    logic       res;
    logic       phi2_up, phi2_dn;
    logic       txmode;
    logic       sp_int;
    logic [7:0] sp_regs;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sp_we;
    logic [3:0] sp_addr;
    logic [7:0] sp_data;
    logic [2:0] level;
    logic       busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ovr;
    logic       rx_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Serial-port model state (owned by the strobe process).
    int         ph;
    int         phi_cnt;
    logic       model_int;
    logic       sr_busy;
    int         sr_cnt;
    logic       sdr_full;
    logic [7:0] sdr;
    int         wr_cnt;
    int         int_cnt;
    logic [7:0] wr_log [64];
    int         wr_phi [64];
    int         wr_int [64];

    logic       man_int;
    logic       model_clr;

    assign sp_int = model_int | man_int;

    always #5 clk = ~clk;

    cia_sp_sequencer #(
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .res      (res),
        .phi2_up  (phi2_up),
        .phi2_dn  (phi2_dn),
        .txmode   (txmode),
        .sp_int   (sp_int),
        .sp_regs  (sp_regs),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sp_we    (sp_we),
        .sp_addr  (sp_addr),
        .sp_data  (sp_data),
        .level    (level),
        .busy     (busy),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ovr   (rx_ovr),
        .rx_ack   (rx_ack)
    );

    // PHI2 = 8 clks: phi2_up on phase 0, phi2_dn on phase 4. Shifting takes 4 PHI2 cycles.
    initial begin
        ph = 0; phi2_up = 1'b0; phi2_dn = 1'b0; phi_cnt = 0;
        model_int = 1'b0; sr_busy = 1'b0; sr_cnt = 0; sdr_full = 1'b0; sdr = 8'h00;
        wr_cnt = 0; int_cnt = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 8;
            phi2_up = (ph == 0);
            phi2_dn = (ph == 4);
            if (phi2_up) phi_cnt++;
            #2;
            if (model_clr) begin
                model_int = 1'b0; sr_busy = 1'b0; sdr_full = 1'b0; sdr = 8'h00;
            end else if (phi2_dn) begin
                model_int = 1'b0;
                if (sr_busy) begin
                    sr_cnt--;
                    if (sr_cnt == 0) begin
                        sr_busy = 1'b0;
                        model_int = 1'b1;
                        int_cnt++;
                    end
                end
                if (!sr_busy && sdr_full) begin
                    sr_busy = 1'b1; sr_cnt = 4; sdr_full = 1'b0;
                end
                if (sp_we && txmode && wr_cnt < 64) begin
                    sdr = sp_data; sdr_full = 1'b1;
                    wr_log[wr_cnt] = sp_data;
                    wr_phi[wr_cnt] = phi_cnt;
                    wr_int[wr_cnt] = int_cnt;
                    wr_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic next_up();
        do tick(); while (!phi2_up);
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 8'h77; res = 1'b1; model_clr = 1'b1;
        txmode = 1'b0; rx_ack = 1'b0; man_int = 1'b0; sp_regs = 8'h00;
        repeat (3) tick();
        in_valid = 1'b0; res = 1'b0; model_clr = 1'b0;
        tick();
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (sp_we !== 1'b0) begin n_fail++; $display("FAIL reset_sp_we: got %b want 0", sp_we); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (sp_addr !== 4'hC) begin n_fail++; $display("FAIL reset_sp_addr: got %h want c", sp_addr); end
        n_checks++; if (sp_data !== 8'h00) begin n_fail++; $display("FAIL reset_sp_data: got %h want 00", sp_data); end
        n_checks++; if (rx_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ovr: got %b want 0", rx_ovr); end
    endtask

    task automatic test_single();
        int k;
        int pc0;
        int w0;
        txmode = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
        pc0 = phi_cnt; w0 = wr_cnt;
        tick();
        in_valid = 1'b0;
        k = 0; while (sp_we !== 1'b1 && k < 40) begin tick(); k++; end
        n_checks++; if (sp_we !== 1'b1) begin n_fail++; $display("FAIL single_we_rise: got %b want 1", sp_we); end
        n_checks++; if (ph != 1) begin n_fail++; $display("FAIL single_we_at_up: phase %0d want 1", ph); end
        n_checks++; if (sp_data !== 8'hA5) begin n_fail++; $display("FAIL single_sp_data: got %h want a5", sp_data); end
        k = 0; while (sp_we !== 1'b0 && k < 40) begin tick(); k++; end
        n_checks++; if (sp_we !== 1'b0) begin n_fail++; $display("FAIL single_we_fall: got %b want 0", sp_we); end
        n_checks++; if (wr_cnt != w0 + 1 || sdr !== 8'hA5) begin n_fail++; $display("FAIL single_sdr: got %h (%0d writes) want a5 (1 write)", sdr, wr_cnt - w0); end
        n_checks++; if (wr_cnt > w0 && wr_phi[w0] - pc0 > 2) begin n_fail++; $display("FAIL single_latency: got %0d phi2 cycles want <=2", wr_phi[w0] - pc0); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_level: got %0d want 0", level); end
        n_checks++; if (dut.outstanding_q !== 2'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d want 1", dut.outstanding_q); end
        k = 0; while (busy !== 1'b0 && k < 200) begin tick(); k++; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [3];
        int k;
        int int0;
        int w0;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        int0 = int_cnt; w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            in_data = b[i]; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        k = 0; while (busy !== 1'b0 && k < 400) begin tick(); k++; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
        n_checks++; if (wr_cnt != w0 + 3) begin n_fail++; $display("FAIL b2b_count: got %0d writes want 3", wr_cnt - w0); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_log[w0 + i] !== b[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, wr_log[w0 + i], b[i]);
            end
        end
        n_checks++; if (wr_phi[w0 + 1] - wr_phi[w0] != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d phi2 cycles want 1", wr_phi[w0 + 1] - wr_phi[w0]); end
        n_checks++; if (wr_int[w0 + 1] - int0 != 0) begin n_fail++; $display("FAIL b2b_second_ints: got %0d want 0", wr_int[w0 + 1] - int0); end
        n_checks++; if (wr_int[w0 + 2] - int0 != 1) begin n_fail++; $display("FAIL b2b_third_ints: got %0d want 1", wr_int[w0 + 2] - int0); end
        n_checks++; if (int_cnt - int0 != 3) begin n_fail++; $display("FAIL b2b_total_ints: got %0d want 3", int_cnt - int0); end
    endtask

    task automatic test_fill();
        int k;
        int w0;
        txmode = 1'b0; w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h41 + 8'(i); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level4: got %0d want 4", level); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        in_data = 8'h45; in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (16) tick();
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_ignored: level %0d want 4", level); end
        n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL fill_no_issue: got %0d writes want 0", wr_cnt - w0); end
        txmode = 1'b1;
        k = 0; while (busy !== 1'b0 && k < 800) begin tick(); k++; end
        n_checks++; if (busy !== 1'b0 || wr_cnt != w0 + 4) begin n_fail++; $display("FAIL fill_drain: busy=%b writes=%0d want 0/4", busy, wr_cnt - w0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_log[w0 + i] !== 8'h41 + 8'(i)) begin
                n_fail++; $display("FAIL fill_order%0d: got %h want %h", i, wr_log[w0 + i], 8'h41 + 8'(i));
            end
        end
    endtask

    task automatic test_abort();
        int k;
        int w0;
        txmode = 1'b1; w0 = wr_cnt;
        in_data = 8'h66; in_valid = 1'b1; tick(); in_valid = 1'b0;
        k = 0; while (sp_we !== 1'b1 && k < 40) begin tick(); k++; end
        n_checks++; if (sp_we !== 1'b1) begin n_fail++; $display("FAIL abort_we_rise: got %b want 1", sp_we); end
        txmode = 1'b0;
        k = 0; while (sp_we !== 1'b0 && k < 40) begin tick(); k++; end
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL abort_no_pop: level %0d want 1", level); end
        n_checks++; if (dut.outstanding_q !== 2'd0) begin n_fail++; $display("FAIL abort_outstanding: got %0d want 0", dut.outstanding_q); end
        repeat (16) tick();
        n_checks++; if (sp_we !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL abort_held: we=%b level=%0d want 0/1", sp_we, level); end
        txmode = 1'b1;
        k = 0; while (busy !== 1'b0 && k < 400) begin tick(); k++; end
        n_checks++; if (wr_cnt != w0 + 1) begin n_fail++; $display("FAIL abort_rewrite_count: got %0d writes want 1", wr_cnt - w0); end
        n_checks++; if (wr_log[w0] !== 8'h66) begin n_fail++; $display("FAIL abort_rewrite_byte: got %h want 66", wr_log[w0]); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL abort_level: got %0d want 0", level); end
    endtask

    task automatic test_reset_mid_write();
        int k;
        txmode = 1'b1;
        in_data = 8'h77; in_valid = 1'b1; tick(); in_valid = 1'b0;
        k = 0; while (sp_we !== 1'b1 && k < 40) begin tick(); k++; end
        n_checks++; if (sp_we !== 1'b1) begin n_fail++; $display("FAIL midres_we_rise: got %b want 1", sp_we); end
        res = 1'b1; model_clr = 1'b1;
        tick();
        n_checks++; if (sp_we !== 1'b0) begin n_fail++; $display("FAIL midres_we: got %b want 0", sp_we); end
        n_checks++; if (level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midres_state: level=%0d busy=%b want 0/0", level, busy); end
        res = 1'b0; model_clr = 1'b0; txmode = 1'b0;
        repeat (2) tick();
    endtask

`ifdef CIA_SP_SEQ_RX_EN
    task automatic test_rx();
        txmode = 1'b0; rx_ack = 1'b0; man_int = 1'b0;
        next_up(); man_int = 1'b1;
        tick(); man_int = 1'b0; sp_regs = 8'hC3;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_armed_not_valid: got %b want 0", rx_valid); end
        next_up(); tick();
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid: got %b want 1", rx_valid); end
        n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rx_data: got %h want c3", rx_data); end
        n_checks++; if (rx_ovr !== 1'b0) begin n_fail++; $display("FAIL rx_no_ovr: got %b want 0", rx_ovr); end
        next_up(); man_int = 1'b1;
        tick(); man_int = 1'b0; sp_regs = 8'h5A;
        next_up(); tick();
        n_checks++; if (rx_ovr !== 1'b1) begin n_fail++; $display("FAIL rx_ovr: got %b want 1", rx_ovr); end
        n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rx_data2: got %h want 5a", rx_data); end
        rx_ack = 1'b1; tick(); rx_ack = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_ack_clear: got %b want 0", rx_valid); end
        n_checks++; if (rx_ovr !== 1'b1) begin n_fail++; $display("FAIL rx_ovr_sticky: got %b want 1", rx_ovr); end
    endtask
`else
    task automatic test_rx();
        txmode = 1'b0; rx_ack = 1'b0;
        next_up(); man_int = 1'b1;
        tick(); man_int = 1'b0; sp_regs = 8'hC3;
        next_up(); tick();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_tied_valid: got %b want 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rx_tied_data: got %h want 00", rx_data); end
        rx_ack = 1'b1; tick(); rx_ack = 1'b0;
        n_checks++; if (rx_ovr !== 1'b0) begin n_fail++; $display("FAIL rx_tied_ovr: got %b want 0", rx_ovr); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_abort();
        test_reset_mid_write();
        test_rx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
